memory_io_responder: RTL and testbench
======================================

MEMORY_IO_RESPONDER -- requirements
Module: memory_io_responder

Interface
REQ-001 Parameter RAM_WORDS, default 256: data RAM depth in 32-bit words, occupying byte addresses 0x000-0x3FF.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for io_input_bus bits.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 address  input  12  byte address from EX stage; word index is address[11:2], and address[1:0] is ignored.
REQ-006 byteena  input  4  byte-lane write enables, lane i = data[8i+7:8i].
REQ-007 data  input  32  write data.
REQ-008 wren  input  1  write request.
REQ-009 q  output  32  registered read data.
REQ-010 io_input_bus  input  14  |13 KEY 10|9 SW 0|; KEY is active-low, 0 = pressed.
REQ-011 io_output_bus  output  52  |51 HEX5 45|44 HEX4 38|37 HEX3 31|30 HEX2 24|23 HEX1 17|16 HEX0 10|9 LED 0|; HEX segments are active-low.

Function
REQ-012 The block SHALL sample address, data, byteena and wren on each rising edge, with no enable and no stall input.
REQ-013 q SHALL present the addressed word in the clock cycle after the sampling edge (1-cycle latency), for both RAM and I/O addresses.
REQ-014 The address map SHALL be:
  - 0x000-0x3FF: RAM, R/W.
  - 0x800: LED[9:0], R/W.
  - 0x804: HEX0[6:0], HEX1[13:7], HEX2[20:14], HEX3[27:21], R/W.
  - 0x808: HEX4[6:0], HEX5[13:7], R/W.
  - 0x810: SW[9:0], synchronized, RO.
  - 0x814: KEY[3:0], synchronized raw level, RO.
  - 0x818: KEY_PRESS[3:0], sticky, write-1-to-clear.
REQ-015 Unmapped addresses SHALL read 0, and writes to them SHALL be ignored; unused upper bits of I/O registers SHALL read 0.
REQ-016 byteena = 4'b0000 with wren = 1 SHALL be treated as a full-word write (4'b1111).
REQ-017 A write SHALL update only the enabled lanes, and the written value SHALL be visible on a read sampled at the next edge or later.
REQ-018 A read and write to the same RAM or I/O word sampled at the same edge SHALL return the old data on q.
REQ-019 Each io_input_bus bit SHALL pass through SYNC_STAGES flip-flops before any use, so register reads reflect a pin change no earlier than SYNC_STAGES+1 edges after it.
REQ-020 KEY_PRESS[i] SHALL set on a synchronized KEY[i] 1->0 transition and hold until cleared.
REQ-021 A write to 0x818 SHALL clear KEY_PRESS bits where data[i] = 1 and lane 0 is enabled.
REQ-022 If a press edge and a clear occur in the same cycle for the same bit, the set SHALL win.
REQ-023 io_output_bus SHALL be driven directly from the LED and HEX registers, with a new value appearing one cycle after the write edge.
REQ-024 RAM contents SHALL come from the initialization file at configuration and SHALL NOT be altered by reset.

Reset
REQ-025 On reset = 1 at a rising edge, the following SHALL hold after that edge:
  - q = 0
  - LED = 0
  - all HEX = 7'h7F (blank)
  - KEY_PRESS = 0
  - KEY synchronizers = 1 (released)
  - SW synchronizers = 0
REQ-026 wren SHALL be ignored at any edge where reset = 1, and reset mid-operation SHALL discard any pending read result.

Verification
REQ-027 Write 0x12345678 to 0x004 with byteena 0000, then write 0xAB to 0x004 with byteena 0001, then read 0x004 -> q = 0x123456AB one cycle after the read edge.
REQ-028 Write 0x3FF to 0x800 and 0x0FFFFFFF to 0x804 -> io_output_bus[9:0] = 0x3FF and [37:10] all 1 one cycle later; then assert reset -> LED = 0, HEX0-5 = 7'h7F.
REQ-029 Drive KEY[2] low for 5 cycles then high -> read 0x818 returns 0x4 after 3 edges and still 0x4 after release; write 0x4 to 0x818 -> subsequent read returns 0x0.
REQ-030 Hold KEY[1] high, clear KEY_PRESS via 0x818, and drop KEY[1] so its synchronized edge lands on the clear edge -> KEY_PRESS[1] = 1 (set wins).
REQ-031 Same-edge write 0xDEADBEEF and read of 0x010 holding 0x0 -> q = 0x0; next read of 0x010 -> q = 0xDEADBEEF.
REQ-032 Read 0x900, then write to 0x900, then read again -> q = 0 both times, and io_output_bus unchanged.

Source files
------------

// File: rtl/memory_io_responder.sv
// memory_io_responder
//   Data-memory responder for a small soft core: a byte-lane writable RAM at
//   0x000-0x3FF plus memory-mapped board I/O (LEDs, six 7-segment digits,
//   switches, push keys with sticky press flags). Reads have one cycle of
//   latency through q. A read and a write of the same word at one edge return
//   the old contents.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high; does not touch RAM contents
//   address[11:0]  byte address; word index is address[11:2]
//   byteena[3:0]   lane write enables (4'b0000 means all lanes)
//   data[31:0]     write data
//   wren           write request
//   q[31:0]        registered read data
//   io_input_bus   {KEY[3:0] (active-low), SW[9:0]}
//   io_output_bus  {HEX5..HEX0 (7 bits each, active-low), LED[9:0]}
module memory_io_responder #(
  parameter int RAM_WORDS   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address,
  input  logic [3:0]  byteena,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q,
  input  logic [13:0] io_input_bus,
  output logic [51:0] io_output_bus
);

  localparam int          AW       = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [10:0] LP_WORDS = 11'(RAM_WORDS);
  localparam logic [13:0] LP_IN_RST = {4'hF, 10'h000};

  localparam logic [9:0] W_LED   = 10'h200;
  localparam logic [9:0] W_HEXLO = 10'h201;
  localparam logic [9:0] W_HEXHI = 10'h202;
  localparam logic [9:0] W_SW    = 10'h204;
  localparam logic [9:0] W_KEY   = 10'h205;
  localparam logic [9:0] W_PRESS = 10'h206;

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_q;
  logic [9:0]  r_led;
  logic [27:0] r_hex_lo;
  logic [13:0] r_hex_hi;
  logic [3:0]  r_key_press;
  logic [3:0]  r_key_prev;
  logic [SYNC_STAGES-1:0][13:0] r_sync;

  logic [9:0]    w_word;
  logic [AW-1:0] w_ram_idx;
  logic          w_ram_hit;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_mask;
  logic [31:0]   w_rdata;
  logic [31:0]   w_merged;
  logic [13:0]   w_in_sync;
  logic [3:0]    w_press;
  logic [3:0]    w_clear;
  logic          w_unused;

  assign w_word    = address[11:2];
  assign w_ram_idx = address[AW+1:2];
  assign w_ram_hit = ({1'b0, w_word} < LP_WORDS);
  assign w_we      = wren & ~reset;
  assign w_be      = (byteena == 4'b0000) ? 4'b1111 : byteena;
  assign w_mask    = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_unused  = &{1'b0, address[1:0]};

  assign w_in_sync = r_sync[SYNC_STAGES-1];
  // Falling edge of the synchronized (active-low) key = a press.
  assign w_press   = r_key_prev & ~w_in_sync[13:10];

  always_comb begin
    w_rdata = 32'h0;
    if (w_ram_hit) begin
      w_rdata = r_ram[w_ram_idx];
    end else begin
      case (w_word)
        W_LED:   w_rdata = {22'h0, r_led};
        W_HEXLO: w_rdata = {4'h0, r_hex_lo};
        W_HEXHI: w_rdata = {18'h0, r_hex_hi};
        W_SW:    w_rdata = {22'h0, w_in_sync[9:0]};
        W_KEY:   w_rdata = {28'h0, w_in_sync[13:10]};
        W_PRESS: w_rdata = {28'h0, r_key_press};
        default: w_rdata = 32'h0;
      endcase
    end
  end

  // Lane merge against the current register image; upper bits beyond each
  // register's width simply fall away.
  assign w_merged = (w_rdata & ~w_mask) | (data & w_mask);

  assign w_clear = (w_we && !w_ram_hit && w_word == W_PRESS && w_be[0]) ?
                   data[3:0] : 4'h0;

  always_ff @(posedge clock) begin
    if (w_we && w_ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_ram[w_ram_idx][8*i +: 8] <= data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= LP_IN_RST;
      r_key_prev <= 4'hF;
    end else begin
      r_sync[0] <= io_input_bus;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_key_prev <= w_in_sync[13:10];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q         <= 32'h0;
      r_led       <= 10'h0;
      r_hex_lo    <= {28{1'b1}};
      r_hex_hi    <= {14{1'b1}};
      r_key_press <= 4'h0;
    end else begin
      r_q <= w_rdata;
      // Set after clear so a simultaneous press is never lost.
      r_key_press <= (r_key_press & ~w_clear) | w_press;
      if (w_we && !w_ram_hit) begin
        case (w_word)
          W_LED:   r_led    <= w_merged[9:0];
          W_HEXLO: r_hex_lo <= w_merged[27:0];
          W_HEXHI: r_hex_hi <= w_merged[13:0];
          default: ;
        endcase
      end
    end
  end

  assign q             = r_q;
  assign io_output_bus = {r_hex_hi, r_hex_lo, r_led};

endmodule

// File: tb/tb_memory_io_responder.sv
module tb_memory_io_responder;

  localparam int S = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address;
  logic [3:0]  byteena;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;
  logic [13:0] io_input_bus;
  logic [51:0] io_output_bus;

  int checks = 0;
  int errors = 0;

  memory_io_responder #(.RAM_WORDS(256), .SYNC_STAGES(S)) dut (
    .clock(clock), .reset(reset), .address(address), .byteena(byteena),
    .data(data), .wren(wren), .q(q), .io_input_bus(io_input_bus),
    .io_output_bus(io_output_bus)
  );

  always #5 clock = ~clock;

  // Reference model: architectural state plus a per-edge history of pin
  // values; a synchronized value seen at edge n is the pin value of edge n-S.
  logic [31:0] m_ram [256];
  logic [9:0]  m_led;
  logic [27:0] m_hex_lo;
  logic [13:0] m_hex_hi;
  logic [3:0]  m_kp;
  logic [31:0] m_q;
  logic [13:0] hist [8192];
  int          n;
  logic [13:0] pins;

  function automatic logic [31:0] model_read(input logic [11:0] a, input logic [13:0] syn);
    if (a[11:10] == 2'b00) return m_ram[a[9:2]];
    case ({a[11:2], 2'b00})
      12'h800: return {22'h0, m_led};
      12'h804: return {4'h0, m_hex_lo};
      12'h808: return {18'h0, m_hex_hi};
      12'h810: return {22'h0, syn[9:0]};
      12'h814: return {28'h0, syn[13:10]};
      12'h818: return {28'h0, m_kp};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [11:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic w);
    logic [13:0] syn;
    logic [3:0]  press, clr, bee;
    logic [31:0] old, nw;
    reset = rst; address = a; byteena = be; data = d; wren = w; io_input_bus = pins;
    @(posedge clock);
    n++;
    if (rst) begin
      for (int j = 0; j <= S; j++) hist[n-j] = 14'h3C00;
      m_q = 32'h0; m_led = 10'h0; m_hex_lo = {28{1'b1}}; m_hex_hi = {14{1'b1}}; m_kp = 4'h0;
    end else begin
      hist[n] = pins;
      syn   = hist[n-S];
      press = hist[n-S-1][13:10] & ~hist[n-S][13:10];
      m_q   = model_read(a, syn);
      clr   = 4'h0;
      if (w) begin
        bee = (be == 4'b0000) ? 4'hF : be;
        old = m_q;
        nw  = old;
        for (int i = 0; i < 4; i++) if (bee[i]) nw[8*i +: 8] = d[8*i +: 8];
        if (a[11:10] == 2'b00) m_ram[a[9:2]] = nw;
        else case ({a[11:2], 2'b00})
          12'h800: m_led    = nw[9:0];
          12'h804: m_hex_lo = nw[27:0];
          12'h808: m_hex_hi = nw[13:0];
          12'h818: if (bee[0]) clr = d[3:0];
          default: ;
        endcase
      end
      m_kp = (m_kp & ~clr) | press;
    end
    #1;
    check("q", {32'h0, q}, {32'h0, m_q});
    check("io_output_bus", {12'h0, io_output_bus}, {12'h0, m_hex_hi, m_hex_lo, m_led});
  endtask

  task automatic rd(input logic [11:0] a);
    step(1'b0, a, 4'h0, $urandom, 1'b0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    step(1'b0, a, be, d, 1'b1);
  endtask

  initial begin
    logic [51:0] saved_bus;
    logic [11:0] ra;
    int sel;
    n = S + 2;
    for (int i = 0; i < 8192; i++) hist[i] = 14'h3C00;
    pins = 14'h3C00;

    step(1'b1, 12'h0, 4'h0, 32'h0, 1'b1);
    step(1'b1, 12'h0, 4'h0, 32'h0, 1'b0);
    check("reset_q", {32'h0, q}, 64'h0);
    check("reset_bus", {12'h0, io_output_bus}, {12'h0, {42{1'b1}}, 10'h0});
    rd(12'h818);
    check("reset_keypress", {32'h0, q}, 64'h0);
    rd(12'h814);
    check("reset_key_sync", {32'h0, q}, 64'hF);

    for (int i = 0; i < 256; i++) wr(12'(i * 4), 4'h0, $urandom);

    // Byte-lane write and full-word default
    wr(12'h004, 4'b0000, 32'h12345678);
    wr(12'h004, 4'b0001, 32'h000000AB);
    rd(12'h004);
    check("lane_write", {32'h0, q}, 64'h123456AB);

    // LED/HEX outputs then reset
    wr(12'h800, 4'b0000, 32'h000003FF);
    wr(12'h804, 4'b0000, 32'h0FFFFFFF);
    check("led_out", {54'h0, io_output_bus[9:0]}, 64'h3FF);
    check("hex03_out", {36'h0, io_output_bus[37:10]}, {36'h0, 28'hFFFFFFF});
    wr(12'h808, 4'b0001, 32'h00000012);
    check("hex4_out", {57'h0, io_output_bus[44:38]}, 64'h12);
    step(1'b1, 12'h800, 4'h0, 32'h1, 1'b1);
    check("reset_led", {54'h0, io_output_bus[9:0]}, 64'h0);
    check("reset_hex", {22'h0, io_output_bus[51:10]}, {22'h0, {42{1'b1}}});

    // Switch synchronizer latency
    pins = 14'h3C00 | 14'h155;
    rd(12'h810);
    check("sw_lat1", {32'h0, q}, 64'h0);
    pins = 14'h3C00 | 14'h155;
    rd(12'h810);
    check("sw_lat2", {32'h0, q}, 64'h0);
    rd(12'h810);
    check("sw_lat3", {32'h0, q}, 64'h155);

    // KEY[2] press, sticky, clear
    pins = 14'h3C00 & ~14'h1000;
    for (int i = 0; i < 5; i++) rd(12'h818);
    rd(12'h818);
    check("press_set", {32'h0, q}, 64'h4);
    pins = 14'h3C00;
    for (int i = 0; i < 4; i++) rd(12'h818);
    check("press_sticky", {32'h0, q}, 64'h4);
    wr(12'h818, 4'b0001, 32'h4);
    rd(12'h818);
    check("press_cleared", {32'h0, q}, 64'h0);

    // Clear with lane 0 disabled does nothing
    pins = 14'h3C00 & ~14'h0400;
    for (int i = 0; i < 4; i++) rd(12'h818);
    pins = 14'h3C00;
    wr(12'h818, 4'b0010, 32'h000000FF);
    rd(12'h818);
    check("clear_lane0_off", {32'h0, q}, 64'h1);
    wr(12'h818, 4'b0001, 32'hF);

    // Set wins over same-edge clear on KEY[1]
    rd(12'h818);
    pins = 14'h3C00 & ~14'h0800;
    rd(12'h818);
    rd(12'h818);
    wr(12'h818, 4'b0001, 32'h2);
    rd(12'h818);
    check("set_wins", {32'h0, q}, 64'h2);
    pins = 14'h3C00;
    for (int i = 0; i < 3; i++) rd(12'h000);

    // Read-during-write returns old data
    wr(12'h010, 4'b1111, 32'h0);
    wr(12'h010, 4'b1111, 32'hDEADBEEF);
    check("rdw_old", {32'h0, q}, 64'h0);
    rd(12'h010);
    check("rdw_new", {32'h0, q}, 64'hDEADBEEF);

    // Unmapped address
    saved_bus = io_output_bus;
    rd(12'h900);
    check("unmapped_rd1", {32'h0, q}, 64'h0);
    wr(12'h900, 4'b0000, 32'hFFFFFFFF);
    check("unmapped_wr", {32'h0, q}, 64'h0);
    rd(12'h900);
    check("unmapped_rd2", {32'h0, q}, 64'h0);
    check("unmapped_bus", {12'h0, io_output_bus}, {12'h0, saved_bus});

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      sel = int'($urandom_range(0, 10));
      case (sel)
        0, 1:    ra = {2'b00, 8'($urandom), 2'($urandom)};
        2:       ra = 12'h800 | 12'($urandom_range(0, 3));
        3:       ra = 12'h804;
        4:       ra = 12'h808;
        5:       ra = 12'h810;
        6:       ra = 12'h814;
        7:       ra = 12'h818;
        8:       ra = 12'h80C;
        9:       ra = 12'h900;
        default: ra = 12'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) pins = 14'($urandom);
      step(($urandom_range(0, 99) == 0), ra, 4'($urandom), $urandom,
           ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
